// File: rtl/qkt_softmax_pkg.sv
// Shared types and constants for the QKT softmax pass engines.
//   SCORE_W      default signed score width
//   score_t      signed score of SCORE_W bits
//   SCORE_MIN    most-negative score_t, the neutral start value of a max reduction
//   pass_state_e state encoding shared by the pass-1/2/3 engines
package qkt_softmax_pkg;

  localparam int SCORE_W = 16;

  typedef logic signed [SCORE_W-1:0] score_t;

  localparam score_t SCORE_MIN = score_t'({1'b1, {(SCORE_W-1){1'b0}}});

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    DONE,
    HOLD
  } pass_state_e;

endpackage

// File: rtl/qkt_rd_addr_gen.sv
// Score buffer read sequencer shared by the softmax pass engines.
// Issues ROW_LEN consecutive reads starting at address 0 after a start pulse.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      begin a new row; rd_addr restarts at 0
//   abort      stop issuing reads at the next edge
//   rd_en      read strobe, high for exactly ROW_LEN cycles per completed row
//   rd_addr    read address 0..ROW_LEN-1, never wraps within a row
//   last       current strobe addresses the final score of the row
module qkt_rd_addr_gen #(
  parameter int ROW_LEN = 64,
  parameter int ADDR_W  = $clog2(ROW_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              last
);

  assign last = rd_en && (rd_addr == ADDR_W'(ROW_LEN - 1));

  // Abort has priority so a dropped enable can never extend a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else if (abort) begin
      rd_en   <= 1'b0;
    end else if (start) begin
      rd_en   <= 1'b1;
      rd_addr <= '0;
    end else if (rd_en) begin
      if (last) begin
        rd_en <= 1'b0;
      end else begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/qkt_pass1_rowmax_engine.sv
// Pass-1 executor of the QKT softmax pipeline: streams one score row from the
// score buffer and reduces it to its signed maximum.
// Optional feature macro: QKT_ROWMAX_ARGMAX_EN adds the row_argmax port.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   enable_pass1   level enable from the controller, held until done_pass1 seen
//   done_pass1     single-cycle completion pulse
//   rd_en, rd_addr score buffer read strobe and address
//   rd_data        buffer data, valid one cycle after rd_en
//   row_max        signed maximum of the last completed row
//   row_max_valid  row_max holds a completed result
//   row_argmax     first index of the maximum (QKT_ROWMAX_ARGMAX_EN only)
module qkt_pass1_rowmax_engine
  import qkt_softmax_pkg::*;
#(
  parameter int DATA_W  = SCORE_W,
  parameter int ROW_LEN = 64,
  parameter int ADDR_W  = $clog2(ROW_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_pass1,
  output logic                     done_pass1,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic signed [DATA_W-1:0] row_max,
  output logic                     row_max_valid
`ifdef QKT_ROWMAX_ARGMAX_EN
  ,
  output logic [ADDR_W-1:0]        row_argmax
`endif
);

  localparam logic signed [DATA_W-1:0] ACC_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  pass_state_e state;
  logic signed [DATA_W-1:0] acc;
  logic data_valid;
  logic gen_start;
  logic gen_abort;
  logic gen_last;
  logic take;

  assign gen_start = (state == IDLE) && enable_pass1;
  assign gen_abort = ((state == READ) || (state == DRAIN)) && !enable_pass1;

  // Strictly greater keeps the earliest index on ties.
  assign take = data_valid && (rd_data > acc);

  qkt_rd_addr_gen #(
    .ROW_LEN (ROW_LEN),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .start   (gen_start),
    .abort   (gen_abort),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .last    (gen_last)
  );

`ifdef QKT_ROWMAX_ARGMAX_EN
  logic [ADDR_W-1:0] idx_pipe;
  logic [ADDR_W-1:0] acc_idx;

  // Address of the sample now on rd_data, aligned with data_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_pipe   <= '0;
      acc_idx    <= '0;
      row_argmax <= '0;
    end else begin
      if (rd_en) idx_pipe <= rd_addr;
      if (take)  acc_idx  <= idx_pipe;
      if (state == DRAIN && enable_pass1) row_argmax <= take ? idx_pipe : acc_idx;
    end
  end
`endif

  // Control FSM plus the running maximum. The final sample is folded in while
  // it is compared (DRAIN), so row_max and done_pass1 update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      done_pass1    <= 1'b0;
      row_max       <= '0;
      row_max_valid <= 1'b0;
      acc           <= ACC_MIN;
      data_valid    <= 1'b0;
    end else begin
      done_pass1 <= 1'b0;
      data_valid <= rd_en && !gen_abort;
      if (take) acc <= rd_data;
      case (state)
        IDLE: begin
          if (enable_pass1) begin
            state         <= READ;
            row_max_valid <= 1'b0;
            acc           <= ACC_MIN;
          end
        end
        READ: begin
          if (!enable_pass1)  state <= IDLE;
          else if (gen_last)  state <= DRAIN;
        end
        DRAIN: begin
          if (!enable_pass1) begin
            state <= IDLE;
          end else begin
            state         <= DONE;
            done_pass1    <= 1'b1;
            row_max       <= take ? rd_data : acc;
            row_max_valid <= 1'b1;
          end
        end
        DONE: state <= HOLD;
        HOLD: if (!enable_pass1) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qkt_pass1_rowmax_engine.sv
// Directed self-checking bench for qkt_pass1_rowmax_engine.
// A ROW_LEN=4 instance covers the handshake/abort/reset cases, a ROW_LEN=1024
// instance covers a long random row. Build with QKT_ROWMAX_ARGMAX_EN defined to
// also check row_argmax.
// Cycle n is the clock period ending at rising edge n; edge t0 is the edge
// that first samples enable_pass1 high, so "done at t0+L+2" means done_pass1
// is visible just after edge t0+L+1.
module tb_qkt_pass1_rowmax_engine;
  import qkt_softmax_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic en_big = 1'b0;

  logic         done_pass1, rd_en, row_max_valid;
  logic [1:0]   rd_addr;
  score_t       rd_data = '0;
  score_t       row_max;
  logic         done_big, rd_en_big, valid_big;
  logic [9:0]   rd_addr_big;
  score_t       rd_data_big = '0;
  score_t       row_max_big;
`ifdef QKT_ROWMAX_ARGMAX_EN
  logic [1:0]   row_argmax;
  logic [9:0]   argmax_big;
`endif

  score_t mem4 [0:3];
  score_t mem_big [0:1023];

  int cyc = 0;
  int done_count = 0;
  int read_count = 0;
  int total = 0;
  int bad = 0;
  int t0;
  int at;
  int done_snap;
  int read_snap;
  score_t ref_max;
  int ref_idx;

  qkt_pass1_rowmax_engine #(.DATA_W(16), .ROW_LEN(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_pass1  (en),
    .done_pass1    (done_pass1),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .row_max       (row_max),
    .row_max_valid (row_max_valid)
`ifdef QKT_ROWMAX_ARGMAX_EN
    ,
    .row_argmax    (row_argmax)
`endif
  );

  qkt_pass1_rowmax_engine #(.DATA_W(16), .ROW_LEN(1024)) dut_big (
    .clk           (clk),
    .rst           (rst),
    .enable_pass1  (en_big),
    .done_pass1    (done_big),
    .rd_en         (rd_en_big),
    .rd_addr       (rd_addr_big),
    .rd_data       (rd_data_big),
    .row_max       (row_max_big),
    .row_max_valid (valid_big)
`ifdef QKT_ROWMAX_ARGMAX_EN
    ,
    .row_argmax    (argmax_big)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // One-cycle-latency score buffers feeding both instances.
  always @(posedge clk) begin
    if (rd_en)     rd_data     <= mem4[rd_addr];
    if (rd_en_big) rd_data_big <= mem_big[rd_addr_big];
  end

  // Edge counter plus done/read tallies for the small instance.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done_pass1) done_count <= done_count + 1;
    if (rd_en)      read_count <= read_count + 1;
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Load a row into the small buffer and raise enable; edge t0 samples it.
  task automatic applyStimulus(input score_t s0, input score_t s1,
                               input score_t s2, input score_t s3);
    mem4[0] = s0;
    mem4[1] = s1;
    mem4[2] = s2;
    mem4[3] = s3;
    @(negedge clk);
    en = 1'b1;
    t0 = cyc + 1;
  endtask

  // Bounded wait for a done pulse; at stays -1 when the budget expires.
  task automatic waitDone(input int limit, input bit big, output int found);
    found = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((big ? done_big : done_pass1) === 1'b1) begin
        found = cyc;
        break;
      end
    end
  endtask

  // Drop enable and let the engine return through HOLD to IDLE.
  task automatic releaseEnable();
    en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    $display("[TB] start");

    // Reset values
    #1;
    checkOutput("rst_done", done_pass1, 0);
    checkOutput("rst_rd_en", rd_en, 0);
    checkOutput("rst_rd_addr", rd_addr, 0);
    checkOutput("rst_row_max", row_max, 0);
    checkOutput("rst_valid", row_max_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: {3,-7,12,5}
    applyStimulus(16'sd3, -16'sd7, 16'sd12, 16'sd5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t1_rd_en", rd_en, 1);
      checkOutput("t1_rd_addr", rd_addr, i);
    end
    waitDone(20, 1'b0, at);
    checkOutput("t1_done_cycle", at, t0 + 5);
    checkOutput("t1_row_max", row_max, 12);
    checkOutput("t1_valid", row_max_valid, 1);
`ifdef QKT_ROWMAX_ARGMAX_EN
    checkOutput("t1_argmax", row_argmax, 2);
`endif
    @(negedge clk);
    checkOutput("t1_done_single", done_pass1, 0);
    releaseEnable();

    // Test 2: sign compare and tie keeps first index
    applyStimulus(-16'sd32768, -16'sd1, -16'sd1, -16'sd200);
    @(negedge clk);
    checkOutput("t2_valid_cleared", row_max_valid, 0);
    waitDone(20, 1'b0, at);
    checkOutput("t2_done_cycle", at, t0 + 5);
    checkOutput("t2_row_max", row_max, -1);
    checkOutput("t2_valid", row_max_valid, 1);
`ifdef QKT_ROWMAX_ARGMAX_EN
    checkOutput("t2_argmax", row_argmax, 1);
`endif
    releaseEnable();

    // Test 3: abort with enable dropped so edge t0+2 samples it low
    done_snap = done_count;
    applyStimulus(16'sd7, 16'sd7, 16'sd7, 16'sd7);
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checkOutput("t3_rd_en_low", rd_en, 0);
    repeat (6) @(negedge clk);
    checkOutput("t3_no_done", done_count - done_snap, 0);
    checkOutput("t3_valid", row_max_valid, 0);
    checkOutput("t3_row_max_held", row_max, -1);
    checkOutput("t3_rd_en_idle", rd_en, 0);

    // Test 4: asynchronous reset in the middle of READ
    applyStimulus(16'sd3, -16'sd7, 16'sd12, 16'sd5);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("t4_rd_en", rd_en, 0);
    checkOutput("t4_rd_addr", rd_addr, 0);
    checkOutput("t4_row_max", row_max, 0);
    checkOutput("t4_valid", row_max_valid, 0);
    checkOutput("t4_done", done_pass1, 0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(-16'sd5, -16'sd9, -16'sd2, -16'sd3);
    waitDone(20, 1'b0, at);
    checkOutput("t4_done_cycle", at, t0 + 5);
    checkOutput("t4_fresh_max", row_max, -2);
`ifdef QKT_ROWMAX_ARGMAX_EN
    checkOutput("t4_argmax", row_argmax, 2);
`endif
    releaseEnable();

    // Test 5: controller drops enable one cycle after seeing done, two rows
    done_snap = done_count;
    read_snap = read_count;
    applyStimulus(16'sd1, 16'sd2, 16'sd3, 16'sd4);
    waitDone(20, 1'b0, at);
    checkOutput("t5a_done_cycle", at, t0 + 5);
    checkOutput("t5a_row_max", row_max, 4);
`ifdef QKT_ROWMAX_ARGMAX_EN
    checkOutput("t5a_argmax", row_argmax, 3);
`endif
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checkOutput("t5a_one_done", done_count - done_snap, 1);
    applyStimulus(16'sd9, 16'sd0, 16'sd0, 16'sd0);
    waitDone(20, 1'b0, at);
    checkOutput("t5b_done_cycle", at, t0 + 5);
    checkOutput("t5b_row_max", row_max, 9);
`ifdef QKT_ROWMAX_ARGMAX_EN
    checkOutput("t5b_argmax", row_argmax, 0);
`endif
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t5_two_dones", done_count - done_snap, 2);
    checkOutput("t5_reads", read_count - read_snap, 8);

    // Test 6: ROW_LEN=1024 random signed row against a reference max
    ref_max = SCORE_MIN;
    ref_idx = 0;
    for (int i = 0; i < 1024; i++) begin
      mem_big[i] = score_t'($urandom);
      if (mem_big[i] > ref_max) begin
        ref_max = mem_big[i];
        ref_idx = i;
      end
    end
    @(negedge clk);
    en_big = 1'b1;
    t0 = cyc + 1;
    waitDone(1100, 1'b1, at);
    checkOutput("t6_done_cycle", at, t0 + 1025);
    checkOutput("t6_row_max", row_max_big, ref_max);
    checkOutput("t6_valid", valid_big, 1);
`ifdef QKT_ROWMAX_ARGMAX_EN
    checkOutput("t6_argmax", argmax_big, ref_idx);
`endif
    en_big = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
